mmio_bus_ctrl: RTL
==================

Name: mmio_bus_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the processor's ADDR/Dout/W outputs and the on-chip RAM and peripherals.
- Generalises the single fixed LED register to N_OUT output port registers.
- Adds a synchronised switch input port, a prescaled tick counter, and a registered read path with a valid strobe.
- All read sources return data with one-cycle latency, matching the synchronous RAM.

Parameters:
- DW, 9, data width of the bus, registers and counter.
- AW, 9, processor address width; the top 2 bits select the region.
- RAM_AW, 7, RAM address width (RAM_AW <= AW-2).
- N_OUT, 2, number of output port registers (1..4).
- PRESCALE, 50, clk cycles per counter tick (>= 1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- addr  in  AW  processor address.
- wdata  in  DW  processor write data.
- w  in  1  write strobe, single cycle.
- rd  in  1  read request, single cycle.
- rdata  out  DW  read data to the processor.
- rvalid  out  1  rdata valid; high for exactly one cycle.
- ram_addr  out  RAM_AW  equals addr[RAM_AW-1:0].
- ram_wren  out  1  RAM write enable.
- ram_data  out  DW  equals wdata.
- ram_q  in  DW  synchronous RAM read data, one-cycle latency.
- sw_in  in  DW  asynchronous switch inputs.
- out_port  out  N_OUT*DW  output port registers; port k occupies bits [k*DW +: DW].

Behaviour:
- Region decode uses r = addr[AW-1:AW-2]:
  - 00 = RAM.
  - 01 = output ports, index addr[1:0].
  - 10 = switch input.
  - 11 = tick counter.
- Reset (resetn low, asynchronous):
  - out_port = 0, rvalid = 0, rdata = 0.
  - sync flops = 0.
  - prescaler = 0, tick counter = 0.
  - registered read select = NONE.
- Writes (w=1, effective at the clock edge):
  - r=00: ram_wren = w, combinational, asserted in the same cycle.
  - r=01 with index < N_OUT: out_port[index] <= wdata.
  - r=01 with index >= N_OUT: ignored.
  - r=10: ignored.
  - r=11: prescaler and tick counter cleared to 0.
  - ram_wren is 0 whenever r != 00.
- Reads (rd=1 in cycle n):
  - Region and index are registered at the edge ending cycle n.
  - The non-RAM source value is captured at that same edge.
  - In cycle n+1: rvalid = 1, and rdata = ram_q (r=00) or the captured value.
  - Captured value by region:
    - r=01 with valid index: out_port[index] pre-write value.
    - r=01 with index >= N_OUT: 0.
    - r=10: sync stage-2 value.
    - r=11: tick counter pre-update value.
  - When rvalid = 0, rdata = 0.
- Back-to-back reads are allowed: rd high in consecutive cycles gives rvalid high in consecutive cycles, each carrying its own data.
- Simultaneous w and rd to the same location is read-before-write:
  - Out ports and counter return the old value.
  - RAM returns whatever the RAM primitive returns (old data for the altsyncram default).
- Switch input:
  - Two-flop synchroniser per bit.
  - An sw_in change is visible in a read captured no earlier than 2 edges later.
- Tick counter:
  - Prescaler counts 0..PRESCALE-1.
  - When it wraps, the DW-bit counter increments.
  - The counter wraps from 2^DW-1 to 0 with no flag.
  - PRESCALE=1 means the counter increments every cycle.
  - A write to r=11 has priority over a same-cycle tick.
- Reset mid-read: a pending rvalid is cancelled, and no rvalid is issued after reset release until a new rd.

Test Plan:
1. Reset, then w=1, addr=0x080, wdata=0x155 → out_port[0]=0x155 next edge, ram_wren stays 0. Then rd addr=0x080 → next cycle rvalid=1, rdata=0x155.
2. w to addr=0x083 (index 3 >= N_OUT=2) with 0x0AA → all out_port unchanged. rd addr=0x083 → rdata=0, rvalid=1.
3. w addr=0x012 data 0x0F0 → ram_wren=1 that cycle, ram_addr=0x12. rd addr=0x012 → rdata=ram_q (0x0F0 with RAM model), rvalid exactly one cycle.
4. PRESCALE=4: after reset, wait 40 cycles, rd addr=0x180 → rdata=10.
   - Write addr=0x180 in the same cycle a tick is due → counter reads 0 afterwards.
   - With DW=9, run 512 ticks from 0 → reads 0 (wrap).
5. sw_in changes 0x000→0x1FF asynchronously → rd addr=0x100 issued 1 edge later returns 0x000; rd issued ≥2 edges later returns 0x1FF.
6. rd to 0x080, 0x100, 0x180 on three consecutive cycles → three consecutive rvalid pulses with the matching data. resetn low in the cycle after one rd → rvalid=0 and out_port=0 immediately, no stale rvalid after release.

Source files
------------

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped I/O decoder: RAM, N_OUT output port registers, synchronised switches and a prescaled tick counter.
// Reads return data one cycle after rd with a single-cycle rvalid; there is no backpressure and writes always land.
module mmio_bus_ctrl #(
  parameter int DW       = 9,
  parameter int AW       = 9,
  parameter int RAM_AW   = 7,
  parameter int N_OUT    = 2,
  parameter int PRESCALE = 50
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  input  logic                w,
  input  logic                rd,
  output logic [DW-1:0]       rdata,
  output logic                rvalid,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic                ram_wren,
  output logic [DW-1:0]       ram_data,
  input  logic [DW-1:0]       ram_q,
  input  logic [DW-1:0]       sw_in,
  output logic [N_OUT*DW-1:0] out_port
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    REG_RAM = 2'b00,
    REG_OUT = 2'b01,
    REG_SW  = 2'b10,
    REG_CNT = 2'b11
  } region_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_RAM  = 2'b01,
    SEL_CAP  = 2'b10
  } rsel_e;

  region_e    region;
  logic [1:0] idx;
  logic       unused_addr;

  assign region      = region_e'(addr[AW-1:AW-2]);
  assign idx         = addr[1:0];
  assign unused_addr = ^addr;

  // RAM side is purely combinational so the RAM sees the write in the same cycle.
  assign ram_addr = addr[RAM_AW-1:0];
  assign ram_data = wdata;
  assign ram_wren = w && (region == REG_RAM);

  // ---------------------------------------------------------------- output ports
  logic [N_OUT-1:0][DW-1:0] out_q, out_d;
  logic [DW-1:0]            out_rd;

  always_comb begin
    out_d  = out_q;
    out_rd = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (idx == 2'(k)) begin
        out_rd = out_q[k];
        if (w && (region == REG_OUT)) begin
          out_d[k] = wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_port = out_q;

  // ---------------------------------------------------------------- switch synchroniser
  logic [DW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------- tick counter
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // A bus write to the counter region wins over a tick due on the same edge.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (w && (region == REG_CNT)) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      cnt_d = cnt_q + DW'(1);
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------- registered read path
  rsel_e         rsel_q, rsel_d;
  logic [DW-1:0] cap_q, cap_d;

  // Non-RAM sources are captured at the request edge so reads see pre-write values.
  always_comb begin
    rsel_d = SEL_NONE;
    cap_d  = cap_q;
    if (rd) begin
      unique case (region)
        REG_RAM: rsel_d = SEL_RAM;
        REG_OUT: begin
          rsel_d = SEL_CAP;
          cap_d  = out_rd;
        end
        REG_SW: begin
          rsel_d = SEL_CAP;
          cap_d  = sync2_q;
        end
        REG_CNT: begin
          rsel_d = SEL_CAP;
          cap_d  = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsel_q <= SEL_NONE;
      cap_q  <= '0;
    end else begin
      rsel_q <= rsel_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    rvalid = 1'b0;
    rdata  = '0;
    case (rsel_q)
      SEL_RAM: begin
        rvalid = 1'b1;
        rdata  = ram_q;
      end
      SEL_CAP: begin
        rvalid = 1'b1;
        rdata  = cap_q;
      end
      default: begin
        rvalid = 1'b0;
        rdata  = '0;
      end
    endcase
  end

endmodule
